// File: rtl/btn_reader.sv
// Pushbutton front end: polarity fix, 2-FF synchroniser and per-button debounce.
// Produces clean levels, one-cycle press/release strobes and a wrapping press counter.
module btn_reader #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               count_clr,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_pressed,
  output logic [7:0]         press_count
);

  localparam int                 CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BTN-1:0] POL      = (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic               r_any;
  logic [7:0]         r_count;
  logic [CW-1:0]      r_cnt [NUM_BTN];

  logic [NUM_BTN-1:0] w_pin;
  logic [NUM_BTN-1:0] w_level_nxt;
  logic [NUM_BTN-1:0] w_press_nxt;
  logic [NUM_BTN-1:0] w_release_nxt;
  logic [CW-1:0]      w_cnt_nxt [NUM_BTN];
  logic [7:0]         w_pop;

  assign w_pin = btn_in ^ POL;

  // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_comb begin
    w_level_nxt = r_level;
    w_pop       = 8'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_level_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
    w_press_nxt   = w_level_nxt & ~r_level;
    w_release_nxt = ~w_level_nxt & r_level;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_pop = w_pop + {7'd0, w_press_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_any     <= 1'b0;
      r_count   <= 8'd0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= w_pin;
      r_sync2   <= r_sync1;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_any     <= |w_level_nxt;
      // Clear wins over presses accepted on the same edge.
      r_count   <= count_clr ? 8'd0 : r_count + w_pop;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign any_pressed = r_any;
  assign press_count = r_count;

endmodule

// File: tb/tb_btn_reader.sv
// Bench for btn_reader: directed vector table, counter wrap sequence and randomized
// stimulus against a sliding-window reference model; an ACTIVE_LOW twin runs on inverted pins.
module tb_btn_reader;

  localparam int NB = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          count_clr = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_in_al = '1;

  logic [NB-1:0] lvl_a, prs_a, rel_a;
  logic          any_a;
  logic [7:0]    cnt_a;
  logic [NB-1:0] lvl_b, prs_b, rel_b;
  logic          any_b;
  logic [7:0]    cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_reader #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .count_clr(count_clr),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a),
    .any_pressed(any_a), .press_count(cnt_a)
  );

  btn_reader #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in_al), .count_clr(count_clr),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b),
    .any_pressed(any_b), .press_count(cnt_b)
  );

  // Reference: a level flips once the last DC synchronised samples all disagree with it.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0;
  logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0, m_nl;
  logic [7:0]    m_count = 8'd0;
  logic          hist [NB][DC];
  bit            all_diff;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_count = 8'd0;
      for (int i = 0; i < NB; i++)
        for (int k = 0; k < DC; k++) hist[i][k] = 1'b0;
    end else begin
      m_nl = m_level;
      for (int i = 0; i < NB; i++) begin
        for (int k = DC - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = m_s2[i];
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++) if (hist[i][k] == m_level[i]) all_diff = 1'b0;
        if (all_diff) m_nl[i] = ~m_level[i];
      end
      m_press = m_nl & ~m_level;
      m_rel   = m_level & ~m_nl;
      m_count = count_clr ? 8'd0 : m_count + 8'($countones(m_press));
      m_level = m_nl;
      m_s2    = m_s1;
      m_s1    = btn_in;
    end
  end

  typedef struct {
    logic          rst_n;
    logic          clr;
    logic [NB-1:0] btn;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [7:0]    cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic c, input logic [1:0] b,
                              input logic [1:0] l, input logic [1:0] p, input logic [1:0] e,
                              input logic [7:0] n, input int reps);
    vec_t v;
    v.rst_n = r; v.clr = c; v.btn = b; v.lvl = l; v.prs = p; v.rel = e; v.cnt = n;
    for (int k = 0; k < reps; k++) tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [NB-1:0] b);
    @(negedge clk);
    rst_n = r; count_clr = c; btn_in = b; btn_in_al = ~b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input logic [1:0] l, input logic [1:0] p,
                                     input logic [1:0] e, input logic a, input logic [7:0] n);
    return {17'd0, l, p, e, a, n};
  endfunction

  logic [NB-1:0] rb;
  logic          rr, rc;
  int            hold;

  initial begin
    // Clean press / release of button 0
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0, 5);
    add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 8'd1, 1);
    add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 8'd1, 1);
    add(1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 8'd1, 5);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 8'd1, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd1, 1);
    // Dual press with clear on the accepting edge, then dual release
    add(1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 8'd1, 5);
    add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 8'd0, 1);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b00, 2'b11, 2'b00, 2'b00, 8'd0, 5);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 8'd0, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    // Bounce 1,0,1,0,1 then held
    add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0, 5);
    add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 8'd1, 1);
    add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 8'd1, 1);
    // Reset while button 1 is mid-debounce and button 0 mid-release
    add(1, 0, 2'b10, 2'b01, 2'b00, 2'b00, 8'd1, 4);
    add(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 1);
    add(1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 5);
    add(1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 8'd1, 1);
    add(1, 0, 2'b10, 2'b10, 2'b00, 2'b00, 8'd1, 1);

    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].rst_n, tbl[v].clr, tbl[v].btn);
      chk($sformatf("vec%0d_hi", v), pk(lvl_a, prs_a, rel_a, any_a, cnt_a),
          pk(tbl[v].lvl, tbl[v].prs, tbl[v].rel, |tbl[v].lvl, tbl[v].cnt));
      chk($sformatf("vec%0d_lo", v), pk(lvl_b, prs_b, rel_b, any_b, cnt_b),
          pk(tbl[v].lvl, tbl[v].prs, tbl[v].rel, |tbl[v].lvl, tbl[v].cnt));
    end

    // Counter wrap: clear, 127 dual presses -> 254, one more -> 0
    step(1, 1, 2'b00);
    for (int k = 0; k < 6; k++) step(1, 0, 2'b00);
    chk("cleared", {24'd0, cnt_a}, 32'd0);
    for (int n = 0; n < 127; n++) begin
      for (int k = 0; k < 6; k++) step(1, 0, 2'b11);
      for (int k = 0; k < 6; k++) step(1, 0, 2'b00);
    end
    chk("preload_254", {24'd0, cnt_a}, 32'd254);
    chk("preload_254_lo", {24'd0, cnt_b}, 32'd254);
    for (int k = 0; k < 6; k++) step(1, 0, 2'b11);
    chk("wrap_0", {24'd0, cnt_a}, 32'd0);
    chk("wrap_0_lo", {24'd0, cnt_b}, 32'd0);
    for (int k = 0; k < 6; k++) step(1, 0, 2'b00);

    // Randomized run against the reference model
    hold = 0;
    rb = '0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        rb   = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 8);
      end
      hold--;
      rr = ($urandom_range(0, 499) != 0);
      rc = ($urandom_range(0, 49) == 0);
      step(rr, rc, rb);
      chk("rand_hi", pk(lvl_a, prs_a, rel_a, any_a, cnt_a),
          pk(m_level, m_press, m_rel, |m_level, m_count));
      chk("rand_lo", pk(lvl_b, prs_b, rel_b, any_b, cnt_b),
          pk(m_level, m_press, m_rel, |m_level, m_count));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_reader.md
Name: btn_reader

Overview:
Input-side companion to the board LED drivers. Samples raw pushbutton pins (Icezum SW1/SW2 and similar) and synchronises them into the clock domain. Debounces each button independently and produces clean levels, one-cycle press/release strobes, and a running press counter for top-level logic (LED patterns, mode selection). Sits directly behind the button input pins in every board top.

Parameters:
NUM_BTN, 2, number of independent button inputs (1..8)
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a new level (10 ms at 12 MHz); minimum 2
ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; inverted at input so all internal logic is "1 = pressed"

Ports:
clk  input  1  system clock (12 MHz on icestick/Icezum)
rst_n  input  1  synchronous active-low reset
btn_in  input  NUM_BTN  raw asynchronous button pins
count_clr  input  1  synchronous clear of press_count
btn_level  output  NUM_BTN  debounced level per button, 1 = pressed
btn_press  output  NUM_BTN  one-cycle strobe when btn_level goes 0->1
btn_release  output  NUM_BTN  one-cycle strobe when btn_level goes 1->0
any_pressed  output  1  OR of btn_level (registered level, same cycle as btn_level)
press_count  output  8  wrapping count of accepted presses, all buttons

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk.
- Reset (rst_n=0 at a rising edge): sync stages, btn_level, btn_press, btn_release, any_pressed, press_count = 0; all debounce counters = 0. Reset applies mid-debounce and mid-strobe: pending transitions are discarded and strobes drop.
- Input conditioning: p[i] = btn_in[i] XOR ACTIVE_LOW, then a 2-FF synchroniser per bit; s[i] is the second stage.
- Debounce per button: counter cnt[i], width $clog2(DEBOUNCE_CYCLES).
  - s[i] == btn_level[i]: cnt[i] <= 0.
  - s[i] != btn_level[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != btn_level[i] and cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= s[i], cnt[i] <= 0.
  - Any single-cycle return to the old level restarts the count from 0.
- Latency: for a clean pin change sampled at edge E, btn_level changes at edge E+1+DEBOUNCE_CYCLES. The synchroniser adds 2 edges, and the accept happens on the DEBOUNCE_CYCLES-th mismatching s sample.
- Strobes are registered:
  - btn_press[i] <= 1 on the same edge that btn_level[i] goes 0->1; btn_release[i] likewise on 1->0.
  - Each strobe is high for exactly one cycle, coincident with the first cycle of the new level.
  - A strobe is never asserted at reset exit, even if a button is held: a held button yields btn_press after the full latency, because btn_level resets to 0.
- press_count:
  - On each edge, press_count <= press_count + popcount(next-cycle btn_press), modulo 256. Simultaneous presses on several buttons all count; 255 + 2 = 1.
  - count_clr=1: press_count <= 0. Clear has priority and presses accepted on that same edge are not counted.
  - press_count updates on the same edge as btn_press.
- Independence: buttons share no state except press_count; simultaneous transitions on different buttons are handled in parallel.

Test Plan:
Use DEBOUNCE_CYCLES=4, NUM_BTN=2, ACTIVE_LOW=0 in simulation.
1. Clean press: btn_in[0] 0->1 sampled at edge 10, held -> btn_level[0]=1 and btn_press[0]=1 at edge 15; btn_press[0]=0 at edge 16; press_count=1; any_pressed=1.
2. Bounce: btn_in[0] toggles 1,0,1,0,1 on consecutive edges, then held 1 -> no strobe during toggling; exactly one btn_press, 5 edges after the last 0->1 sample; press_count increments by 1.
3. Release and simultaneous press: both buttons released together -> btn_release=2'b11 for one cycle. Both pressed on the same edge -> btn_press=2'b11 and press_count +2; preload to 254 by repeated presses, then a dual press -> press_count=0.
4. Clear priority: count_clr=1 on the same edge a press is accepted -> press_count=0 (not 1), while btn_press still pulses.
5. Reset mid-debounce: button held, rst_n=0 after 2 mismatch cycles for 1 edge -> all outputs 0. After release of reset with the button still held, btn_press fires 1+DEBOUNCE_CYCLES+1 edges later, and none at reset exit.
6. ACTIVE_LOW=1: idle pin 1 -> btn_level=0; pin driven 0 -> btn_press after the same latency as scenario 1.
